// File: rtl/hazard_pkg.sv
// Shared constants for the hazard scoreboard: default widths, the result
// latencies decode drives onto id_lat, and branch-type codes.
package hazard_pkg;

    localparam int REG_AW = 5;
    localparam int LAT_W  = 3;

    // ALU latency is 0 when the EX/MEM bypass network is present, 2 without it.
    localparam logic [LAT_W-1:0] LAT_ALU_FWD    = 3'd0;
    localparam logic [LAT_W-1:0] LAT_ALU_NO_FWD = 3'd2;
    localparam logic [LAT_W-1:0] LAT_ALU        = LAT_ALU_FWD;
    localparam logic [LAT_W-1:0] LAT_LOAD       = 3'd1;
    localparam logic [LAT_W-1:0] LAT_MUL        = 3'd4;

    typedef enum logic [1:0] {
        NO_BRANCH = 2'b00,
        BEZ       = 2'b01,
        BNE       = 2'b10,
        JMP       = 2'b11
    } branch_t;

endpackage

// File: rtl/hazard_sb_cell.sv
// One scoreboard entry: a countdown of cycles until a register's pending
// result is readable from ID. Priority is freeze, load, decrement, hold.
module hazard_sb_cell #(
    parameter int LAT_W = hazard_pkg::LAT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic [LAT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (freeze) begin
            cnt <= cnt;
        end else if (load) begin
            // Newest producer overrides any older pending count (WAW).
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown hazard detector beside the ID stage.
// Define HAZARD_PERF_EN to add the perf_stall_cycles counter output.
module hazard_scoreboard #(
    parameter int REG_AW   = hazard_pkg::REG_AW,
    parameter int NUM_REGS = 2 ** REG_AW,
    parameter int LAT_W    = hazard_pkg::LAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src1_used,
    input  logic              id_src2_used,
    input  logic              id_wb_en,
    input  logic [REG_AW-1:0] id_dest,
    input  logic [LAT_W-1:0]  id_lat,
    input  logic              flush,
    input  logic              freeze,
    output logic              stall,
    output logic [1:0]        stall_src
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles
`endif
);

    // Handshake: the ID instruction issues on a cycle with
    // id_valid & ~stall & ~flush & ~freeze; stall acts as the inverse of ready
    // and depends only on current counters and ID inputs, never on flush/freeze.

    logic [LAT_W-1:0] cnt [NUM_REGS];
    logic             issue;
    logic             src1_busy;
    logic             src2_busy;

    assign cnt[0] = '0;

    genvar r;
    generate
        for (r = 1; r < NUM_REGS; r++) begin : g_cell
            hazard_sb_cell #(
                .LAT_W (LAT_W)
            ) u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .freeze   (freeze),
                .load     (issue & id_wb_en & (id_dest == REG_AW'(r))),
                .load_val (id_lat),
                .cnt      (cnt[r])
            );
        end
    endgenerate

    assign src1_busy = (id_src1 != '0) && (cnt[id_src1] != '0);
    assign src2_busy = (id_src2 != '0) && (cnt[id_src2] != '0);

    always_comb begin
        stall_src    = 2'b00;
        stall_src[0] = id_valid & id_src1_used & src1_busy;
        stall_src[1] = id_valid & id_src2_used & src2_busy;
    end

    assign stall = |stall_src;
    assign issue = id_valid & ~stall & ~flush & ~freeze;

`ifdef HAZARD_PERF_EN
    // Frozen cycles are not charged to hazards; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
        end else if (stall & ~freeze) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the fixed two-destination-compare hazard detector. It uses a per-register countdown scoreboard, so producers of any result latency (ALU, load, multi-cycle unit) are tracked without one comparator per pipeline stage. It sits beside the ID stage and asserts `stall` while any used source register of the instruction in ID has a pending write. It also honours a global pipeline freeze.

## Interface
- `REG_AW`, default 5: register address width; register 0 is hard-wired zero and never tracked.
- `NUM_REGS`, default 32: tracked registers, `2**REG_AW`.
- `LAT_W`, default 3: width of `id_lat` and of each countdown counter.
- `clk` in 1: the single clock; everything is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: a valid instruction is in ID.
- `id_src1` in REG_AW: source 1 address.
- `id_src2` in REG_AW: source 2 address.
- `id_src1_used` in 1: source 1 is read.
- `id_src2_used` in 1: source 2 is read. Decode clears it for immediate forms except BNE, which reads both registers.
- `id_wb_en` in 1: the instruction writes `id_dest`.
- `id_dest` in REG_AW: destination address.
- `id_lat` in LAT_W: cycles the result is unavailable to a following ID read; 0 means fully bypassed and not tracked.
- `flush` in 1: the ID instruction is squashed this cycle, with no issue.
- `freeze` in 1: the whole pipeline is held, e.g. by the memory wait; counters hold.
- `stall` out 1: the ID instruction must hold.
- `stall_src` out 2: bit0 means src1 is blocking, bit1 means src2 is blocking.

## Operation
- Scoreboard: `cnt[r]` has LAT_W bits for r in 1..NUM_REGS-1. `cnt[0]` reads as constant 0.
- Hazard check, combinational from current `cnt`:
  - `stall_src[0] = id_valid & id_src1_used & (id_src1!=0) & (cnt[id_src1]!=0)`; bit1 is the same for src2.
  - `stall = |stall_src`.
- Issue: `issue = id_valid & ~stall & ~flush & ~freeze`.
- Counter update per register r, priority top-down:
  1. `freeze`: hold.
  2. `issue & id_wb_en & id_dest==r & r!=0`: load `id_lat`.
  3. `cnt[r]!=0`: decrement by 1.
  4. Otherwise hold at 0.
- An issue to r loads `id_lat` even if `cnt[r]` is nonzero; the newest producer wins (WAW).
- A self-dependency (src == dest) checks the old `cnt` value, then loads the new one.
- `flush` does not clear counters. Older in-flight producers still complete.
- No saturation is needed: the load value is bounded by LAT_W and decrement stops at 0.

## Timing
- `stall` and `stall_src` are combinational from `cnt` and the ID inputs. There is no internal latency on the check.
- Producer issue at edge t: `cnt[dest] = id_lat` after t. A consumer in ID stalls for exactly `id_lat` unfrozen cycles and issues on the cycle `cnt` reaches 0.
- Each `freeze` cycle extends the stall by one cycle.
- Reset, asynchronous on `rst_n` low: all `cnt` = 0, so `stall` = 0 and `stall_src` = 0 whenever `id_valid` = 0. Performance counter = 0.
- Reset mid-stall drops `stall` immediately. Pending hazards are discarded; the pipeline is reset with it.

## Configuration
- `HAZARD_PERF_EN` defined:
  - Adds output `perf_stall_cycles` (out, 32 bits).
  - It increments on every cycle with `stall & ~freeze`, wraps at 2^32, and resets to 0.
- `HAZARD_PERF_EN` not defined: the port and counter are absent. Functional behaviour is identical.

## Structure
- Shared package `hazard_pkg`: default widths (`REG_AW`, `LAT_W`) and latency constants, which decode drives onto `id_lat`:
  - `LAT_ALU` = 0 with forwarding, or 2 without.
  - `LAT_LOAD` = 1.
  - `LAT_MUL` = 4.
  - Branch-type codes: NO_BRANCH = 2'b00, BEZ = 2'b01, BNE = 2'b10, JMP = 2'b11.
- One sub-module, `hazard_sb_cell`: a single register's counter with load/decrement/hold priority, instantiated in a generate loop for r = 1..NUM_REGS-1.

## Test plan
- Reset, then ID src1=3 used with no prior issue: `stall`=0, `stall_src`=00.
- Issue dest=5, `id_lat`=2; next cycle src2=5 used: `stall`=1 for exactly 2 cycles with `stall_src`=10, then 0.
- Issue dest=0, `id_lat`=3; consumer src1=0: never stalls. Also a src with `id_srcN_used`=0 matching a pending dest: no stall.
- Issue dest=7, lat=2, then `freeze` held 3 cycles; consumer src1=7: stall lasts 5 cycles. Assert `rst_n`=0 mid-stall: `stall` falls asynchronously.
- WAW: issue dest=4 lat=1, then dest=4 lat=3 the next cycle. Consumer then stalls 3 cycles; the second load overrides the counter.
- `HAZARD_PERF_EN` build: run the 2-cycle stall scenario with 1 interleaved freeze cycle; `perf_stall_cycles`=2.
